// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: top-level game sequencer for the pong datapath.
// Tracks IDLE/PLAY/SERVE/OVER, keeps scores, counts rally hits and
// freezes the ball (gra_still) everywhere except PLAY.
// Optional feature macro: RALLY_SPEEDUP_EN (rally-driven speed levels).
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 120,
    parameter int OVER_FRAMES  = 180,
    parameter int RALLY_STEP   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic [3:0] btn,
    input  logic [1:0] hit,
    input  logic [1:0] miss,
    output logic       gra_still,
    output logic [1:0] game_state,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [7:0] rally,
    output logic [1:0] speed_level
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_SERVE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Out-of-range parameters stop elaboration rather than misbehave silently
    if (WIN_SCORE < 1 || WIN_SCORE > 15 || SERVE_FRAMES < 1 || SERVE_FRAMES > 255 ||
        OVER_FRAMES < 1 || OVER_FRAMES > 255 || RALLY_STEP < 1 || RALLY_STEP > 255) begin : g_bad_params
        $error("pong_game_ctrl: parameter out of range");
    end

    state_t      state_reg;
    logic        btn_any_reg;
    logic [1:0]  hit_reg;
    logic [7:0]  timer_reg;
    logic [3:0]  score_l_reg;
    logic [3:0]  score_r_reg;
    logic [1:0]  winner_reg;
    logic [7:0]  rally_reg;
    logic        gra_still_reg;

    logic        press;
    logic [1:0]  hit_evt;
    logic [1:0]  hit_cnt;
    logic [8:0]  rally_sum;
    logic [7:0]  rally_sat;
    logic        idle_start;
    logic        play_miss;
    logic [3:0]  new_score;
    logic        win_next;

    // Edge detection, rally arithmetic and the scoring decision
    always_comb begin
        press      = (|btn) & ~btn_any_reg;
        hit_evt    = hit & ~hit_reg;
        hit_cnt    = {1'b0, hit_evt[0]} + {1'b0, hit_evt[1]};
        rally_sum  = {1'b0, rally_reg} + {7'b0, hit_cnt};
        rally_sat  = rally_sum[8] ? 8'hFF : rally_sum[7:0];
        idle_start = (state_reg == ST_IDLE) && press;
        play_miss  = (state_reg == ST_PLAY) && (miss != 2'b00);
        // miss[0] wins when both bits are set in the same clock
        new_score  = miss[0] ? (score_l_reg + 4'd1) : (score_r_reg + 4'd1);
        win_next   = (new_score == 4'(WIN_SCORE));
    end

    // Game FSM with registered outputs, scores, rally and frame timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            btn_any_reg   <= 1'b0;
            hit_reg       <= 2'b00;
            timer_reg     <= 8'd0;
            score_l_reg   <= 4'd0;
            score_r_reg   <= 4'd0;
            winner_reg    <= 2'b00;
            rally_reg     <= 8'd0;
            gra_still_reg <= 1'b1;
        end else begin
            btn_any_reg <= |btn;
            hit_reg     <= hit;
            case (state_reg)
                ST_IDLE: begin
                    gra_still_reg <= 1'b1;
                    if (press) begin
                        state_reg     <= ST_PLAY;
                        gra_still_reg <= 1'b0;
                        score_l_reg   <= 4'd0;
                        score_r_reg   <= 4'd0;
                        winner_reg    <= 2'b00;
                        rally_reg     <= 8'd0;
                    end
                end
                ST_PLAY: begin
                    gra_still_reg <= 1'b0;
                    rally_reg     <= rally_sat;
                    if (play_miss) begin
                        rally_reg     <= 8'd0;
                        gra_still_reg <= 1'b1;
                        if (miss[0]) begin
                            score_l_reg <= new_score;
                        end else begin
                            score_r_reg <= new_score;
                        end
                        if (win_next) begin
                            state_reg  <= ST_OVER;
                            winner_reg <= miss[0] ? 2'b01 : 2'b10;
                            timer_reg  <= 8'(OVER_FRAMES);
                        end else begin
                            state_reg  <= ST_SERVE;
                            timer_reg  <= 8'(SERVE_FRAMES);
                        end
                    end
                end
                ST_SERVE: begin
                    gra_still_reg <= 1'b1;
                    // Only an edge seen after expiry serves; earlier presses have already passed
                    if (timer_reg == 8'd0 && press) begin
                        state_reg     <= ST_PLAY;
                        gra_still_reg <= 1'b0;
                    end else if (refresh_tick && timer_reg != 8'd0) begin
                        timer_reg <= timer_reg - 8'd1;
                    end
                end
                default: begin // ST_OVER
                    gra_still_reg <= 1'b1;
                    if (timer_reg == 8'd0) begin
                        state_reg <= ST_IDLE;
                    end else if (refresh_tick) begin
                        timer_reg <= timer_reg - 8'd1;
                    end
                end
            endcase
        end
    end

`ifdef RALLY_SPEEDUP_EN
    logic [7:0]  step_cnt_reg;
    logic [1:0]  speed_reg;
    logic [9:0]  step_sum;
    logic [9:0]  step_one;
    logic [9:0]  step_two;
    logic [1:0]  crossings;
    logic [9:0]  step_left;
    logic [2:0]  speed_sum;
    logic [1:0]  speed_sat;

    // Count RALLY_STEP boundaries crossed this clock (up to two hits per clock)
    always_comb begin
        step_sum  = {2'b0, step_cnt_reg} + {8'b0, hit_cnt};
        step_one  = 10'(RALLY_STEP);
        step_two  = 10'(2 * RALLY_STEP);
        crossings = 2'd0;
        step_left = step_sum;
        if (step_sum >= step_two) begin
            crossings = 2'd2;
            step_left = step_sum - step_two;
        end else if (step_sum >= step_one) begin
            crossings = 2'd1;
            step_left = step_sum - step_one;
        end
        speed_sum = {1'b0, speed_reg} + {1'b0, crossings};
        speed_sat = speed_sum[2] ? 2'd3 : speed_sum[1:0];
    end

    // Speed level follows the rally; cleared when a new rally starts from a serve or a new game
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt_reg <= 8'd0;
            speed_reg    <= 2'd0;
        end else if (idle_start || (play_miss && !win_next)) begin
            step_cnt_reg <= 8'd0;
            speed_reg    <= 2'd0;
        end else if (play_miss) begin
            step_cnt_reg <= 8'd0;
        end else if (state_reg == ST_PLAY) begin
            step_cnt_reg <= step_left[7:0];
            speed_reg    <= speed_sat;
        end
    end

    assign speed_level = speed_reg;
`else
    assign speed_level = 2'd0;
`endif

    assign gra_still  = gra_still_reg;
    assign game_state = state_reg;
    assign score_l    = score_l_reg;
    assign score_r    = score_r_reg;
    assign winner     = winner_reg;
    assign rally      = rally_reg;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game sequencer for the pong datapath. Consumes the graphics block's per-clock hit/miss status and player buttons, keeps scores, and drives gra_still to freeze and recentre the ball between serves. Runs a frame-based serve/game-over timer from the 60 Hz refresh tick. Outputs state, scores and winner for the text/score overlay.

Parameters:
WIN_SCORE, 7, points needed to win; range 1..15.
SERVE_FRAMES, 120, refresh ticks of hold-off before a serve is allowed (2 s); range 1..255.
OVER_FRAMES, 180, refresh ticks spent in OVER before returning to IDLE; range 1..255.
RALLY_STEP, 4, paddle hits per speed level (optional feature only); range 1..255.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
refresh_tick  in  1  one-clock pulse per frame (start of vertical retrace)
btn  in  4  paddle buttons, level; any bit counts as "press"
hit  in  2  paddle-hit status from graphics; bit0 left, bit1 right; may stay high several clocks
miss  in  2  miss status; bit0 ball past right edge (left scores), bit1 past left edge (right scores)
gra_still  out  1  freeze/recentre ball when 1
game_state  out  2  0 IDLE, 1 PLAY, 2 SERVE, 3 OVER
score_l  out  4  left player score, binary
score_r  out  4  right player score, binary
winner  out  2  01 left won, 10 right won, 00 none
rally  out  8  paddle hits in current rally, saturates at 255
speed_level  out  2  ball/paddle speed level for datapath

Behaviour:
- Reset values: game_state IDLE, gra_still 1, score_l/score_r 0, winner 00, rally 0, speed_level 0, timer 0, button/hit edge registers 0.
- All outputs registered; gra_still = 1 in every state except PLAY.
- press = rising edge of (|btn), from a one-clock-delayed copy; a button held through a state entry does not count.
- hit_evt[i] = rising edge of hit[i]; multi-cycle hit pulses count once.
- IDLE: on press -> PLAY next clock; same edge clears scores, winner, rally, speed_level.
- PLAY: rally increments by 1 per hit_evt (both bits in one clock: +2, saturating).
  - On first clock with miss != 00, the next clock updates the score and leaves PLAY.
  - miss[0] -> score_l+1; miss[1] -> score_r+1; both set -> miss[0] only.
  - New score == WIN_SCORE -> OVER: winner set, timer loaded with OVER_FRAMES. Else -> SERVE: timer loaded with SERVE_FRAMES.
  - rally cleared on leaving PLAY.
  - misses arriving outside PLAY are ignored. Scores never exceed WIN_SCORE.
- SERVE: timer decrements on refresh_tick while nonzero.
  - Once timer == 0, press -> PLAY.
  - press before timer expiry is discarded; a new edge is required after expiry.
- OVER: timer decrements on refresh_tick; at 0 -> IDLE. Scores and winner hold until the next IDLE press.
- Timer is 8 bits and never wraps below 0.
- refresh_tick and a state transition in the same clock: the transition wins; the timer load takes precedence over the decrement.
- Reset mid-game returns to IDLE values asynchronously; there is no partial state.

Optional Feature:
Macro RALLY_SPEEDUP_EN.
- Defined: speed_level increments by 1 each time rally crosses a multiple of RALLY_STEP, saturating at 3. It resets to 0 on entering SERVE or IDLE->PLAY.
- Undefined: speed_level is constant 0 and no step counter logic exists.

Test Plan:
- Reset, then btn=0001 pulse -> game_state 1, gra_still 0 one clock after the press edge; scores 0.
- In PLAY, miss=01 held 10 clocks -> score_l=1 exactly once, game_state 2, gra_still 1; press before 120 ticks ignored; press after 120th tick -> PLAY.
- Left scores 7 times (WIN_SCORE=7) -> game_state 3, winner 01; after 180 refresh ticks -> IDLE; next press clears scores to 0.
- hit=01 held 5 clocks, then hit=10 held 3 clocks -> rally=2; 300 hit events -> rally=255 (saturated).
- miss=11 in one clock -> score_l+1 only; reset asserted mid-SERVE -> all outputs at reset values immediately.
- With RALLY_SPEEDUP_EN, RALLY_STEP=4: 12 hit events -> speed_level=3; 16 -> stays 3; after a miss -> 0. Without the macro -> always 0.
